hdmi_packet_scheduler: RTL and testbench
========================================

# hdmi_packet_scheduler

Per-slot packet scheduler for the HDMI data-island path. On every data-island packet slot it picks one packet from the audio sample, audio clock regeneration (ACR), AVI, audio (AIF) and source product description (SPD) InfoFrame sources, or a null packet. It registers the chosen header and subpackets for the TMDS packet assembler. It sits between the packet generators and the packet assembler, in the pixel clock domain.

## Interface
- `NULL_ON_IDLE`, default 1: 1 = emit a null packet (type 0x00) on slots with nothing pending; 0 = hold `packet_strobe` low on such slots.
- `clk_pixel`  in  1  pixel clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `frame_start`  in  1  one-cycle pulse per video frame; marks all enabled InfoFrames pending.
- `slot_start`  in  1  one-cycle pulse at the start of each packet slot; the scheduling decision is made here.
- `audio_valid`  in  1  an audio sample packet is available.
- `audio_header` / `audio_sub`  in  24 / 224  audio sample packet; `sub` is {sub3,sub2,sub1,sub0}, 56 bits each.
- `acr_req`  in  1  one-cycle pulse requesting one ACR packet.
- `acr_header` / `acr_sub`  in  24 / 224  ACR packet.
- `avi_header` / `avi_sub`, `aif_header` / `aif_sub`, `spd_header` / `spd_sub`  in  24 / 224 each  InfoFrame packets; quasi-static.
- `audio_ack`  out  1  one-cycle pulse: the audio sample was consumed.
- `packet_strobe`  out  1  one-cycle pulse: a new packet is on `header`/`sub`.
- `packet_type`  out  8  type of the current packet, equal to `header[7:0]`.
- `header`  out  24  header of the current packet.
- `sub`  out  224  subpackets of the current packet.
- `infoframe_missed`  out  8  saturating count of frames in which an InfoFrame went unsent.

## Operation
- Pending state:
  - `acr_pend`: set by `acr_req`, cleared when ACR is sent.
  - `if_pend[2:0]` {SPD, AIF, AVI}: all set by `frame_start`, each bit cleared when its InfoFrame is sent.
- Selection is made at `slot_start` using the pending state and `audio_valid` sampled in that cycle. Strict priority:
  1. audio (`audio_valid`=1);
  2. ACR (`acr_pend`);
  3. AVI, then AIF, then SPD;
  4. null packet, or nothing when `NULL_ON_IDLE`=0.
- Source data is sampled in the `slot_start` cycle.
- Null packet: `header`=0, `sub`=0.
- Same-cycle set and clear:
  - `acr_req` coinciding with `slot_start` that selects ACR: `acr_pend` ends at 1 (set wins).
  - `frame_start` coinciding with the selection of an InfoFrame: that InfoFrame's bit ends at 1 (set wins).
- Missed InfoFrame: if `frame_start` arrives while any `if_pend` bit is still 1, `infoframe_missed` increments by 1. It saturates at 255 and is cleared only by reset.
- A second `acr_req` while `acr_pend`=1 is absorbed; ACR requests do not queue.
- `frame_start` does not start a slot by itself.

## Timing
- `slot_start` in cycle t gives, in cycle t+1:
  - `packet_strobe` = 1;
  - `header`, `sub` and `packet_type` updated;
  - `audio_ack` = 1 if audio was chosen.
- `header`, `sub` and `packet_type` then hold until the next `slot_start` that emits a packet.
- `audio_ack` is coincident with `packet_strobe`. The audio source advances on `audio_ack`; it must not deassert `audio_valid` between cycle t and `audio_ack`.
- Pending bits update at the end of cycle t.
- `slot_start` pulses are at least 2 cycles apart. Behaviour with back-to-back pulses is undefined.
- Reset values:
  - outputs: `packet_strobe`, `audio_ack`, `header`, `sub`, `packet_type` and `infoframe_missed` all 0;
  - state: all pending bits 0.
- Reset asserted mid-operation: all of the above return to reset values immediately; no partial packet is held.

## Configuration
- `HDMI_SCHED_SPD_EN` defined: SPD takes part in scheduling as described above.
- `HDMI_SCHED_SPD_EN` undefined:
  - the SPD pending bit is tied to 0, so SPD is never sent;
  - SPD never counts toward `infoframe_missed`;
  - `spd_header`/`spd_sub` ports remain but are ignored.

## Test plan
- Reset, then `frame_start` and three `slot_start` pulses with no audio and no ACR -> `packet_type` sequence 0x82, 0x84, 0x83; a fourth slot -> 0x00 with `header`=0.
- `audio_valid`=1 held, `acr_req` pending, InfoFrames pending, 2 slots -> 0x02 with `audio_ack` on both slots; drop `audio_valid`, next slot -> 0x01.
- `acr_req` in the same cycle as a `slot_start` that selects ACR -> ACR sent, `acr_pend`=1 afterwards, next idle slot -> 0x01 again.
- `frame_start` twice with no slots in between -> `infoframe_missed`=1; 300 such frames -> holds at 255.
- Without `HDMI_SCHED_SPD_EN`: `frame_start` and 3 slots -> 0x82, 0x84, 0x00; next `frame_start` -> `infoframe_missed` stays 0.
- `rst_n` pulsed low between `slot_start` and `packet_strobe` -> no strobe, all outputs 0, pending cleared.

Source files
------------

// File: rtl/hdmi_packet_scheduler.sv
// Per-slot HDMI data-island packet scheduler: picks audio, ACR, AVI/AIF/SPD InfoFrames or null.
// Optional SPD scheduling is enabled by defining HDMI_SCHED_SPD_EN.
module hdmi_packet_scheduler #(
  parameter bit NULL_ON_IDLE = 1'b1
) (
  input  logic         clk_pixel,
  input  logic         rst_n,
  input  logic         frame_start,
  input  logic         slot_start,
  input  logic         audio_valid,
  input  logic [23:0]  audio_header,
  input  logic [223:0] audio_sub,
  input  logic         acr_req,
  input  logic [23:0]  acr_header,
  input  logic [223:0] acr_sub,
  input  logic [23:0]  avi_header,
  input  logic [223:0] avi_sub,
  input  logic [23:0]  aif_header,
  input  logic [223:0] aif_sub,
  input  logic [23:0]  spd_header,
  input  logic [223:0] spd_sub,
  output logic         audio_ack,
  output logic         packet_strobe,
  output logic [7:0]   packet_type,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic [7:0]   infoframe_missed
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_NULL,
    SEL_AUDIO,
    SEL_ACR,
    SEL_AVI,
    SEL_AIF,
    SEL_SPD
  } sel_e;

  // InfoFrame pending bit order is {SPD, AIF, AVI}.
`ifdef HDMI_SCHED_SPD_EN
  localparam logic [2:0] IF_EN_MASK = 3'b111;
`else
  localparam logic [2:0] IF_EN_MASK = 3'b011;
`endif

  logic         acr_pend, acr_pend_d;
  logic [2:0]   if_pend, if_pend_d, if_clr;
  logic [7:0]   missed_d;
  sel_e         sel;
  logic [23:0]  header_d;
  logic [223:0] sub_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    sel      = NULL_ON_IDLE ? SEL_NULL : SEL_NONE;
    header_d = '0;
    sub_d    = '0;
    if (audio_valid)     sel = SEL_AUDIO;
    else if (acr_pend)   sel = SEL_ACR;
    else if (if_pend[0]) sel = SEL_AVI;
    else if (if_pend[1]) sel = SEL_AIF;
    else if (if_pend[2]) sel = SEL_SPD;

    case (sel)
      SEL_AUDIO: begin header_d = audio_header; sub_d = audio_sub; end
      SEL_ACR:   begin header_d = acr_header;   sub_d = acr_sub;   end
      SEL_AVI:   begin header_d = avi_header;   sub_d = avi_sub;   end
      SEL_AIF:   begin header_d = aif_header;   sub_d = aif_sub;   end
      SEL_SPD:   begin header_d = spd_header;   sub_d = spd_sub;   end
      default:   begin header_d = '0;           sub_d = '0;        end
    endcase
  end

  // Clears apply only on a slot; sets from acr_req/frame_start take precedence.
  always_comb begin
    if_clr     = 3'b000;
    acr_pend_d = acr_pend;
    if (slot_start) begin
      case (sel)
        SEL_AVI: if_clr = 3'b001;
        SEL_AIF: if_clr = 3'b010;
        SEL_SPD: if_clr = 3'b100;
        default: if_clr = 3'b000;
      endcase
      if (sel == SEL_ACR) acr_pend_d = 1'b0;
    end
    if (acr_req) acr_pend_d = 1'b1;

    if_pend_d = (if_pend & ~if_clr) | (frame_start ? IF_EN_MASK : 3'b000);
    if_pend_d = if_pend_d & IF_EN_MASK;

    missed_d = infoframe_missed;
    if (frame_start && (|if_pend) && (infoframe_missed != 8'hFF))
      missed_d = infoframe_missed + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      acr_pend         <= 1'b0;
      if_pend          <= 3'b000;
      infoframe_missed <= 8'd0;
      packet_strobe    <= 1'b0;
      audio_ack        <= 1'b0;
      header           <= '0;
      sub              <= '0;
    end else begin
      acr_pend         <= acr_pend_d;
      if_pend          <= if_pend_d;
      infoframe_missed <= missed_d;
      packet_strobe    <= slot_start && (sel != SEL_NONE);
      audio_ack        <= slot_start && (sel == SEL_AUDIO);
      if (slot_start && (sel != SEL_NONE)) begin
        header <= header_d;
        sub    <= sub_d;
      end
    end
  end

  assign packet_type = header[7:0];

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed self-checking bench for hdmi_packet_scheduler (default NULL_ON_IDLE=1).
module tb_hdmi_packet_scheduler;

  localparam logic [23:0]  AUD_H = 24'h000F02;
  localparam logic [223:0] AUD_S = {4{56'h11_2233_4455_6677}};
  localparam logic [23:0]  ACR_H = 24'h000001;
  localparam logic [223:0] ACR_S = {4{56'h00_0018_0000_1800}};
  localparam logic [23:0]  AVI_H = 24'h0D0282;
  localparam logic [223:0] AVI_S = {4{56'hA5_A5A5_0102_0304}};
  localparam logic [23:0]  AIF_H = 24'h0A0184;
  localparam logic [223:0] AIF_S = {4{56'h5A_5A5A_0506_0708}};
  localparam logic [23:0]  SPD_H = 24'h190183;
  localparam logic [223:0] SPD_S = {4{56'hC3_C3C3_090A_0B0C}};

  logic         clk_pixel = 1'b0;
  logic         rst_n, frame_start, slot_start, audio_valid, acr_req;
  logic         audio_ack, packet_strobe;
  logic [7:0]   packet_type, infoframe_missed;
  logic [23:0]  header;
  logic [223:0] sub;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_packet_scheduler dut (
    .clk_pixel        (clk_pixel),
    .rst_n            (rst_n),
    .frame_start      (frame_start),
    .slot_start       (slot_start),
    .audio_valid      (audio_valid),
    .audio_header     (AUD_H),
    .audio_sub        (AUD_S),
    .acr_req          (acr_req),
    .acr_header       (ACR_H),
    .acr_sub          (ACR_S),
    .avi_header       (AVI_H),
    .avi_sub          (AVI_S),
    .aif_header       (AIF_H),
    .aif_sub          (AIF_S),
    .spd_header       (SPD_H),
    .spd_sub          (SPD_S),
    .audio_ack        (audio_ack),
    .packet_strobe    (packet_strobe),
    .packet_type      (packet_type),
    .header           (header),
    .sub              (sub),
    .infoframe_missed (infoframe_missed)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // One slot pulse; afterwards outputs show the t+1 packet, then one idle cycle keeps slots 2 apart.
  task automatic slot(input string tag, input logic [7:0] exp_type, input logic exp_ack,
                      input logic [23:0] exp_h, input logic [223:0] exp_s);
    slot_start = 1'b1;
    tick();
    slot_start = 1'b0;
    check({tag, "_strobe"}, packet_strobe, 1'b1);
    check({tag, "_type"}, packet_type, exp_type);
    check({tag, "_ack"}, audio_ack, exp_ack);
    check({tag, "_header"}, header, exp_h);
    check({tag, "_sub"}, sub, exp_s);
    tick();
    check({tag, "_strobe_low"}, packet_strobe, 1'b0);
    check({tag, "_hold"}, header, exp_h);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; slot_start = 1'b0;
    audio_valid = 1'b0; acr_req = 1'b0;
    tick(); tick();
    check("rst_strobe", packet_strobe, 1'b0);
    check("rst_ack", audio_ack, 1'b0);
    check("rst_type", packet_type, 8'h00);
    check("rst_header", header, 24'h0);
    check("rst_sub", sub, 224'h0);
    check("rst_missed", infoframe_missed, 8'd0);
    rst_n = 1'b1;
    tick();

    // InfoFrame order after a frame start, then null.
    pulse_frame();
    slot("if_avi", 8'h82, 1'b0, AVI_H, AVI_S);
    slot("if_aif", 8'h84, 1'b0, AIF_H, AIF_S);
`ifdef HDMI_SCHED_SPD_EN
    slot("if_spd", 8'h83, 1'b0, SPD_H, SPD_S);
`endif
    slot("if_null", 8'h00, 1'b0, 24'h0, 224'h0);

    // All sent: next frame does not count a miss; a second unserviced one does.
    pulse_frame();
    check("missed_none", infoframe_missed, 8'd0);
    pulse_frame();
    check("missed_one", infoframe_missed, 8'd1);

    // Audio outranks ACR and pending InfoFrames.
    acr_req = 1'b1; tick(); acr_req = 1'b0;
    audio_valid = 1'b1;
    slot("aud_0", 8'h02, 1'b1, AUD_H, AUD_S);
    slot("aud_1", 8'h02, 1'b1, AUD_H, AUD_S);
    audio_valid = 1'b0;
    slot("acr_0", 8'h01, 1'b0, ACR_H, ACR_S);

    // acr_req coinciding with the slot that sends ACR leaves it pending.
    acr_req = 1'b1; tick();
    slot_start = 1'b1;
    tick();
    slot_start = 1'b0; acr_req = 1'b0;
    check("acr_same_type", packet_type, 8'h01);
    check("acr_same_strobe", packet_strobe, 1'b1);
    tick();
    slot("acr_again", 8'h01, 1'b0, ACR_H, ACR_S);
    slot("after_acr_avi", 8'h82, 1'b0, AVI_H, AVI_S);
    slot("after_acr_aif", 8'h84, 1'b0, AIF_H, AIF_S);
`ifdef HDMI_SCHED_SPD_EN
    slot("after_acr_spd", 8'h83, 1'b0, SPD_H, SPD_S);
`endif
    slot("after_acr_null", 8'h00, 1'b0, 24'h0, 224'h0);

    // Saturation: first pulse sets pending with no miss, each later one counts.
    for (int i = 0; i < 10; i++) pulse_frame();
    check("missed_10", infoframe_missed, 8'd10);
    for (int i = 0; i < 290; i++) pulse_frame();
    check("missed_sat", infoframe_missed, 8'd255);

    // frame_start in the cycle AVI is selected: AVI stays pending.
    frame_start = 1'b1; slot_start = 1'b1;
    tick();
    frame_start = 1'b0; slot_start = 1'b0;
    check("fs_same_type", packet_type, 8'h82);
    check("fs_same_missed", infoframe_missed, 8'd255);
    tick();
    slot("fs_again_avi", 8'h82, 1'b0, AVI_H, AVI_S);

    // Reset lands after slot_start is raised but before the capturing edge.
    acr_req = 1'b1; tick(); acr_req = 1'b0;
    slot_start = 1'b1;
    #3 rst_n = 1'b0;
    tick();
    slot_start = 1'b0;
    check("midrst_strobe", packet_strobe, 1'b0);
    check("midrst_header", header, 24'h0);
    check("midrst_sub", sub, 224'h0);
    check("midrst_type", packet_type, 8'h00);
    check("midrst_missed", infoframe_missed, 8'd0);
    rst_n = 1'b1;
    tick();
    slot("midrst_null", 8'h00, 1'b0, 24'h0, 224'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
